wb_arb_xbar: RTL and testbench

- Parametrised shared-bus Wishbone B3 interconnect: NM masters, NS slaves, one transaction in flight at a time.
- Successor to the fixed 8x16 connection matrix. Adds round-robin master arbitration, top-bits address decode with unmapped-address error, bus-timeout error, and optional generalised address folding (the data-port KSEG remap).
- Sits between the CPU instruction/data ports (plus future DMA/debug masters) and BRAM, GPIO decoder and peripheral slaves.

---
 rtl/wb_arb_xbar.sv | 198 +++++++++++++++++++
 tb/tb_wb_arb_xbar.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arb_xbar.sv
// Shared-bus Wishbone B3 interconnect: round-robin master arbitration, top-bits slave decode,
// optional top-nibble address folding, unmapped-address and bus-timeout error generation.
module wb_arb_xbar #(
    parameter int          NM        = 2,
    parameter int          NS        = 4,
    parameter int          AW        = 32,
    parameter int          DW        = 32,
    parameter int          DEC_BITS  = 4,
    parameter int          TIMEOUT   = 255,
    parameter int          REMAP_EN  = 1,
    parameter int          REMAP_BIT = 28,
    parameter logic [3:0]  REMAP_NIB = 4'h2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NM-1:0]          m_cyc_i,
    input  logic [NM-1:0]          m_stb_i,
    input  logic [NM-1:0]          m_we_i,
    input  logic [NM*(DW/8)-1:0]   m_sel_i,
    input  logic [NM*AW-1:0]       m_adr_i,
    input  logic [NM*DW-1:0]       m_dat_i,
    output logic [NM*DW-1:0]       m_dat_o,
    output logic [NM-1:0]          m_ack_o,
    output logic [NM-1:0]          m_err_o,
    output logic [NS-1:0]          s_cyc_o,
    output logic [NS-1:0]          s_stb_o,
    output logic                   s_we_o,
    output logic [DW/8-1:0]        s_sel_o,
    output logic [AW-1:0]          s_adr_o,
    output logic [DW-1:0]          s_dat_o,
    input  logic [NS*DW-1:0]       s_dat_i,
    input  logic [NS-1:0]          s_ack_i,
    input  logic [NS-1:0]          s_err_i,
    output logic [NM-1:0]          gnt_o,
    output logic                   busy_o
);
    localparam int SW = DW / 8;
    localparam int RW = (NM > 1) ? $clog2(NM) : 1;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OWN  = 1'b1;

    logic [0:0]          r_state;
    logic [RW-1:0]       r_gidx;
    logic [RW-1:0]       r_rr;
    logic [NM-1:0]       r_gnt;
    logic [7:0]          r_tcnt;
    logic                r_err;
    logic                r_sup;

    logic                w_own;
    logic                w_cyc, w_stb, w_we;
    logic [SW-1:0]       w_sel;
    logic [AW-1:0]       w_adr_raw, w_adr;
    logic [DW-1:0]       w_dat;
    logic [DEC_BITS-1:0] w_idx;
    logic [NS-1:0]       w_hit;
    logic                w_map, w_sack, w_serr;
    logic [DW-1:0]       w_sdat;
    logic [RW-1:0]       w_pick;
    logic [NM-1:0]       w_pick_oh;

    // First requester strictly after rr, wrapping; rr itself is considered last.
    function automatic logic [RW-1:0] f_rr_pick(input logic [NM-1:0] req, input logic [RW-1:0] rr);
        logic [RW-1:0] pick;
        logic          found;
        int            j;
        pick  = rr;
        found = 1'b0;
        for (int k = 1; k <= NM; k++) begin
            j = (int'(rr) + k) % NM;
            if (!found && req[j]) begin
                pick  = RW'(j);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign w_own  = (r_state == ST_OWN);
    assign w_pick = f_rr_pick(m_cyc_i, r_rr);

    always_comb begin
        w_pick_oh = '0;
        for (int k = 0; k < NM; k++) w_pick_oh[k] = (w_pick == RW'(k));
    end

    always_comb begin
        w_cyc     = 1'b0;
        w_stb     = 1'b0;
        w_we      = 1'b0;
        w_sel     = '0;
        w_adr_raw = '0;
        w_dat     = '0;
        for (int k = 0; k < NM; k++) begin
            if (w_own && r_gidx == RW'(k)) begin
                w_cyc     = m_cyc_i[k];
                w_stb     = m_stb_i[k];
                w_we      = m_we_i[k];
                w_sel     = m_sel_i[k*SW +: SW];
                w_adr_raw = m_adr_i[k*AW +: AW];
                w_dat     = m_dat_i[k*DW +: DW];
            end
        end
    end

    always_comb begin
        w_adr = w_adr_raw;
        if (REMAP_EN != 0 && w_adr_raw[REMAP_BIT]) w_adr[AW-1 -: 4] = REMAP_NIB;
    end

    assign w_idx = w_adr[AW-1 -: DEC_BITS];

    always_comb begin
        w_hit  = '0;
        w_sack = 1'b0;
        w_serr = 1'b0;
        w_sdat = '0;
        for (int i = 0; i < NS; i++) begin
            if (w_own && w_idx == DEC_BITS'(i)) begin
                w_hit[i] = 1'b1;
                w_sack   = s_ack_i[i];
                w_serr   = s_err_i[i];
                w_sdat   = s_dat_i[i*DW +: DW];
            end
        end
    end

    assign w_map = |w_hit;

    // A pending forced error masks the strobe so the slave cannot complete the aborted access.
    assign s_cyc_o = w_hit & {NS{w_cyc}};
    assign s_stb_o = w_hit & {NS{w_stb && !r_err}};
    assign s_we_o  = w_we;
    assign s_sel_o = w_sel;
    assign s_adr_o = w_adr;
    assign s_dat_o = w_dat;
    assign gnt_o   = r_gnt;
    assign busy_o  = w_own;

    always_comb begin
        m_ack_o = '0;
        m_err_o = '0;
        m_dat_o = '0;
        for (int k = 0; k < NM; k++) begin
            if (w_own && r_gidx == RW'(k)) begin
                m_ack_o[k]          = w_sack && !r_err;
                m_err_o[k]          = r_err || (w_serr && !w_sack);
                m_dat_o[k*DW +: DW] = w_sdat;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
            r_gidx  <= '0;
            r_rr    <= '0;
            r_gnt   <= '0;
            r_tcnt  <= '0;
            r_err   <= 1'b0;
            r_sup   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            r_sup <= r_err;
            case (r_state)
                ST_IDLE: begin
                    r_tcnt <= '0;
                    if (|m_cyc_i) begin
                        r_state <= ST_OWN;
                        r_gidx  <= w_pick;
                        r_rr    <= w_pick;
                        r_gnt   <= w_pick_oh;
                    end
                end
                default: begin
                    if (!w_cyc) begin
                        r_state <= ST_IDLE;
                        r_gnt   <= '0;
                        r_tcnt  <= '0;
                    end else begin
                        // r_sup keeps a master still holding stb after a miss from a second pulse.
                        if (w_stb && !w_map && !r_err && !r_sup) r_err <= 1'b1;
                        if (w_stb && w_map && !r_err && !w_sack && !w_serr) begin
                            if (r_tcnt == 8'(TIMEOUT - 1)) begin
                                r_err  <= 1'b1;
                                r_tcnt <= '0;
                            end else begin
                                r_tcnt <= r_tcnt + 8'd1;
                            end
                        end else begin
                            r_tcnt <= '0;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_arb_xbar.sv
// Directed bench for wb_arb_xbar: main instance (folding on, TIMEOUT=8) and a no-fold twin on the same inputs.
module tb_wb_arb_xbar;
    logic          clk = 1'b0;
    logic          rst_i;
    logic [1:0]    m_cyc, m_stb, m_we;
    logic [7:0]    m_sel;
    logic [63:0]   m_adr, m_dat;
    logic [127:0]  s_dat_i;
    logic [3:0]    s_ack_i, s_err_i;

    wire  [63:0]   m_dat_o, nf_m_dat_o;
    wire  [1:0]    m_ack_o, m_err_o, nf_m_ack_o, nf_m_err_o;
    wire  [3:0]    s_cyc_o, s_stb_o, nf_s_cyc_o, nf_s_stb_o;
    wire           s_we_o, nf_s_we_o;
    wire  [3:0]    s_sel_o, nf_s_sel_o;
    wire  [31:0]   s_adr_o, s_dat_o, nf_s_adr_o, nf_s_dat_o;
    wire  [1:0]    gnt_o, nf_gnt_o;
    wire           busy_o, nf_busy_o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    wb_arb_xbar #(.NM(2), .NS(4), .TIMEOUT(8)) u_dut (
        .clk_i(clk), .rst_i(rst_i),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_sel_i(m_sel),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_dat_o(m_dat_o),
        .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i), .gnt_o(gnt_o), .busy_o(busy_o)
    );

    wb_arb_xbar #(.NM(2), .NS(4), .TIMEOUT(8), .REMAP_EN(0)) u_nofold (
        .clk_i(clk), .rst_i(rst_i),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_sel_i(m_sel),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_dat_o(nf_m_dat_o),
        .m_ack_o(nf_m_ack_o), .m_err_o(nf_m_err_o),
        .s_cyc_o(nf_s_cyc_o), .s_stb_o(nf_s_stb_o), .s_we_o(nf_s_we_o), .s_sel_o(nf_s_sel_o),
        .s_adr_o(nf_s_adr_o), .s_dat_o(nf_s_dat_o), .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i), .gnt_o(nf_gnt_o), .busy_o(nf_busy_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int k, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
        m_cyc[k]         = cyc;
        m_stb[k]         = stb;
        m_we[k]          = we;
        m_adr[k*32 +: 32] = adr;
        m_sel[k*4 +: 4]  = sel;
        m_dat[k*32 +: 32] = dat;
    endtask

    initial begin
        logic [1:0] exp_g;
        rst_i = 1'b0;
        m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '0; m_adr = '0; m_dat = '0;
        s_dat_i = '0; s_ack_i = '0; s_err_i = '0;

        // Reset state
        repeat (2) tick();
        #1;
        chk("rst_gnt", 64'(gnt_o), 64'h0);
        chk("rst_busy", 64'(busy_o), 64'h0);
        chk("rst_scyc", 64'(s_cyc_o), 64'h0);
        chk("rst_merr", 64'(m_err_o), 64'h0);

        // Single read from slave 0: grant one cycle after cyc, data concurrent with ack
        rst_i = 1'b1;
        set_m(0, 1, 1, 0, 32'h0000_0010, 4'hF, 32'h0);
        #1;
        chk("rd_gnt_pre", 64'(gnt_o), 64'h0);
        tick();
        s_ack_i = 4'b0001;
        s_dat_i[31:0] = 32'hDEAD_BEEF;
        #1;
        chk("rd_gnt", 64'(gnt_o), 64'h1);
        chk("rd_sstb", 64'(s_stb_o), 64'h1);
        chk("rd_ack", 64'(m_ack_o), 64'h1);
        chk("rd_dat", 64'(m_dat_o[31:0]), 64'hDEAD_BEEF);
        tick();
        s_ack_i = '0;
        set_m(0, 0, 0, 0, 32'h0, 4'h0, 32'h0);
        #1;
        chk("rd_ack_off", 64'(m_ack_o), 64'h0);
        tick();
        #1;
        chk("rd_idle", 64'(busy_o), 64'h0);

        // Round-robin: rr=0 after m0's grant, so m1 wins first, then alternation
        set_m(0, 1, 1, 0, 32'h0000_0010, 4'hF, 32'h0);
        set_m(1, 1, 1, 0, 32'h0000_0100, 4'hF, 32'h0);
        for (int it = 0; it < 4; it++) begin
            exp_g = (it % 2 == 0) ? 2'b10 : 2'b01;
            tick();
            s_ack_i = 4'hF;
            #1;
            chk("rr_gnt", 64'(gnt_o), 64'(exp_g));
            chk("rr_ack", 64'(m_ack_o), 64'(exp_g));
            tick();
            s_ack_i = '0;
            if (exp_g[0]) set_m(0, 0, 0, 0, 32'h0000_0010, 4'hF, 32'h0);
            else          set_m(1, 0, 0, 0, 32'h0000_0100, 4'hF, 32'h0);
            #1;
            chk("rr_hold", 64'(gnt_o), 64'(exp_g));
            tick();
            #1;
            chk("rr_gap", 64'({busy_o, gnt_o}), 64'h0);
            if (it < 3) begin
                if (exp_g[0]) set_m(0, 1, 1, 0, 32'h0000_0010, 4'hF, 32'h0);
                else          set_m(1, 1, 1, 0, 32'h0000_0100, 4'hF, 32'h0);
            end else begin
                set_m(0, 0, 0, 0, 32'h0, 4'h0, 32'h0);
                set_m(1, 0, 0, 0, 32'h0, 4'h0, 32'h0);
            end
        end

        // Folding: 0x1000_0004 has bit 28 set -> top nibble 2 on folded instance
        set_m(0, 1, 1, 1, 32'h1000_0004, 4'b0011, 32'h0000_1234);
        tick();
        #1;
        chk("fold_adr", 64'(s_adr_o), 64'h2000_0004);
        chk("fold_stb", 64'(s_stb_o), 64'b0100);
        chk("fold_sel", 64'(s_sel_o), 64'b0011);
        chk("fold_we_dat", 64'({s_we_o, s_dat_o}), 64'h1_0000_1234);
        chk("nofold_stb", 64'(nf_s_stb_o), 64'b0010);
        chk("nofold_adr", 64'(nf_s_adr_o), 64'h1000_0004);
        s_ack_i = 4'hF;
        #1;
        chk("fold_ack", 64'(m_ack_o), 64'h1);
        tick();
        s_ack_i = '0;
        set_m(0, 0, 0, 0, 32'h0, 4'h0, 32'h0);
        tick();

        // Unmapped: 0x7000_0000 misses on the no-fold instance, 0x6000_0000 misses on both
        for (int p = 0; p < 2; p++) begin
            set_m(1, 1, 1, 0, (p == 0) ? 32'h7000_0000 : 32'h6000_0000, 4'hF, 32'h0);
            tick();
            #1;
            if (p == 0) begin
                chk("um_nf_stb", 64'(nf_s_stb_o), 64'h0);
                chk("um_nf_err0", 64'(nf_m_err_o), 64'h0);
                chk("um_fold_stb", 64'(s_stb_o), 64'b0100);
            end else begin
                chk("um_stb", 64'(s_stb_o), 64'h0);
                chk("um_err0", 64'(m_err_o), 64'h0);
            end
            tick();
            #1;
            if (p == 0) chk("um_nf_err1", 64'(nf_m_err_o), 64'b10);
            else        chk("um_err1", 64'({m_ack_o, m_err_o}), 64'b0010);
            tick();
            #1;
            if (p == 0) chk("um_nf_err2", 64'(nf_m_err_o), 64'h0);
            else        chk("um_err2", 64'(m_err_o), 64'h0);
            tick();
            #1;
            if (p == 0) chk("um_nf_sup", 64'(nf_m_err_o), 64'h0);
            else        chk("um_sup", 64'(m_err_o), 64'h0);
            set_m(1, 0, 0, 0, 32'h0, 4'h0, 32'h0);
            tick();
        end
        chk("um_fold_noerr", 64'(m_err_o), 64'h0);

        // Timeout: slave never acks; 8 strobe cycles then a forced 1-cycle error
        set_m(0, 1, 1, 0, 32'h3000_0000, 4'hF, 32'h0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            #1;
            if (k == 1) begin
                chk("to_stb", 64'(s_stb_o), 64'b0100);
                chk("to_nf_stb", 64'(nf_s_stb_o), 64'b1000);
            end
            chk("to_wait", 64'(m_err_o), 64'h0);
        end
        tick();
        #1;
        chk("to_err", 64'(m_err_o), 64'h1);
        chk("to_stb_mask", 64'(s_stb_o), 64'h0);
        chk("to_nf_err", 64'(nf_m_err_o), 64'h1);
        tick();
        #1;
        chk("to_err_end", 64'(m_err_o), 64'h0);
        chk("to_stb_back", 64'(s_stb_o), 64'b0100);
        set_m(0, 0, 0, 0, 32'h0, 4'h0, 32'h0);
        tick();

        // Ack on the 8th strobe cycle beats the timeout
        set_m(0, 1, 1, 0, 32'h3000_0000, 4'hF, 32'h0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 8) s_ack_i = 4'hF;
            #1;
            if (k < 8) chk("to2_wait", 64'(m_err_o), 64'h0);
            else       chk("to2_ack", 64'({m_ack_o, m_err_o}), 64'b0100);
        end
        tick();
        s_ack_i = '0;
        #1;
        chk("to2_noerr", 64'(m_err_o), 64'h0);
        set_m(0, 0, 0, 0, 32'h0, 4'h0, 32'h0);
        tick();

        // Reset while m0 owns the bus with stb high
        set_m(0, 1, 1, 0, 32'h0000_0010, 4'hF, 32'h0);
        tick();
        #1;
        chk("mr_own", 64'(gnt_o), 64'h1);
        set_m(1, 1, 1, 0, 32'h0000_0100, 4'hF, 32'h0);
        rst_i = 1'b0;
        s_ack_i = 4'hF;
        tick();
        #1;
        chk("mr_scyc_stb", 64'({s_cyc_o, s_stb_o}), 64'h0);
        chk("mr_gnt_busy", 64'({gnt_o, busy_o}), 64'h0);
        chk("mr_ack", 64'(m_ack_o), 64'h0);
        rst_i = 1'b1;
        s_ack_i = '0;
        tick();
        #1;
        chk("mr_regrant", 64'(gnt_o), 64'b10);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
